aes_mixcol_engine: RTL

//  Sequential AES MixColumns/InvMixColumns engine for a full 128-bit state with valid/ready handshakes.

---
 rtl/aes_mixcol_engine_pkg.sv | 22 ++
 rtl/aes_mixcol_engine_if.sv | 24 ++
 rtl/aes_mixcol_engine_word.sv | 48 ++++
 rtl/aes_mixcol_engine.sv | 117 +++++++++++
 4 files changed

// File: rtl/aes_mixcol_engine_pkg.sv
// Shared definitions for the AES MixColumns engine.
//  - AES_POLY : reduction constant for GF(2^8) doubling
//  - word_t   : one 32-bit state column, row 0 in the MSB byte
//  - state_e  : engine FSM states
//  - xtime/x4 : multiply a byte by 2 / by 4 in GF(2^8)
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] x4(input logic [7:0] b);
    return xtime(xtime(b));
  endfunction

endpackage

// File: rtl/aes_mixcol_engine_if.sv
// Handshake bundle for aes_mixcol_engine.
//  in_valid/in_ready/in_inv/in_state : state offered to the engine
//  out_valid/out_ready/out_state     : mixed state returned
//  modport slave  : engine side
//  modport master : producer/consumer side
interface aes_mixcol_engine_if;
  logic         in_valid;
  logic         in_ready;
  logic         in_inv;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  modport slave (
    input  in_valid, in_inv, in_state, out_ready,
    output in_ready, out_valid, out_state
  );

  modport master (
    output in_valid, in_inv, in_state, out_ready,
    input  in_ready, out_valid, out_state
  );
endinterface

// File: rtl/aes_mixcol_engine_word.sv
// aes_mixcol_word: combinational mix of one AES column.
//  col : input column (row 0 = bits 31:24)
//  inv : 1 = InvMixColumns (only honoured when AES_MIXCOL_INV_EN is defined)
//  res : mixed column, same byte layout
// With AES_MIXCOL_INV_EN, the inverse is the forward mix applied to the
// pre-term (a^u, b^v, c^u, d^v), u = 4(a^c), v = 4(b^d).
module aes_mixcol_word
  import aes_pkg::*;
(
  input  word_t col,
  input  logic  inv,
  output word_t res
);

  logic [7:0] pa, pb, pc, pd;

`ifdef AES_MIXCOL_INV_EN
  logic [7:0] u, v;

  always_comb begin
    u  = x4(col[31:24] ^ col[15:8]);
    v  = x4(col[23:16] ^ col[7:0]);
    pa = col[31:24];
    pb = col[23:16];
    pc = col[15:8];
    pd = col[7:0];
    if (inv) begin
      pa = col[31:24] ^ u;
      pb = col[23:16] ^ v;
      pc = col[15:8]  ^ u;
      pd = col[7:0]   ^ v;
    end
  end
`else
  logic unused_inv;
  assign unused_inv = inv;
  assign pa = col[31:24];
  assign pb = col[23:16];
  assign pc = col[15:8];
  assign pd = col[7:0];
`endif

  assign res = {xtime(pa) ^ xtime(pb) ^ pb ^ pc ^ pd,
                pa ^ xtime(pb) ^ xtime(pc) ^ pc ^ pd,
                pa ^ pb ^ xtime(pc) ^ xtime(pd) ^ pd,
                xtime(pa) ^ pa ^ pb ^ pc ^ xtime(pd)};

endmodule

// File: rtl/aes_mixcol_engine.sv
// aes_mixcol_engine: sequential MixColumns/InvMixColumns over a 128-bit state.
//  clk, rst_n : clock, asynchronous active-low reset
//  bus        : aes_mixcol_engine_if.slave (in_valid/in_ready/in_inv/in_state,
//               out_valid/out_ready/out_state); column c = in_state[127-32c -: 32]
//  COLS_PER_CYCLE (1, 2, 4): columns mixed per clock; a state takes 4/COLS cycles.
// Optional feature: define AES_MIXCOL_INV_EN to build the inverse path;
// otherwise in_inv is ignored and every state is forward-mixed.
module aes_mixcol_engine
  import aes_pkg::*;
#(
  parameter int unsigned COLS_PER_CYCLE = 4
)(
  input  logic                 clk,
  input  logic                 rst_n,
  aes_mixcol_engine_if.slave   bus
);

  localparam int unsigned BEATS = (COLS_PER_CYCLE == 0) ? 1 : 4 / COLS_PER_CYCLE;

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("aes_mixcol_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  state_e        state_q, state_d;
  logic [1:0]    beat_q, beat_d;
  logic [127:0]  work_q, work_d;
  logic          accept;
  logic          last_beat;
  logic          mode_inv;
  word_t         mix_in  [COLS_PER_CYCLE];
  word_t         mix_out [COLS_PER_CYCLE];

`ifdef AES_MIXCOL_INV_EN
  logic mode_q;
  assign mode_inv = mode_q;
`else
  logic unused_in_inv;
  assign unused_in_inv = bus.in_inv;
  assign mode_inv      = 1'b0;
`endif

  // LSB position of the j-th column handled on a given beat.
  function automatic logic [6:0] col_lsb(input logic [1:0] beat, input int unsigned j);
    int unsigned col;
    col = 32'(beat) * COLS_PER_CYCLE + j;
    return 7'(32 * (3 - col));
  endfunction

  assign bus.in_ready  = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_state = work_q;
  assign accept        = bus.in_valid && bus.in_ready;
  assign last_beat     = (beat_q == 2'(BEATS - 1));

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: if (accept) state_d = BUSY;
      BUSY: begin
        if (last_beat) begin
          state_d = DONE;
          beat_d  = '0;
        end else begin
          beat_d  = beat_q + 2'd1;
        end
      end
      DONE: if (bus.out_ready) state_d = accept ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int unsigned j = 0; j < COLS_PER_CYCLE; j++) begin
      mix_in[j] = work_q[col_lsb(beat_q, j) +: 32];
    end
  end

  // Write-back kept in its own block so the word mixers don't form a comb loop.
  always_comb begin
    work_d = work_q;
    for (int unsigned j = 0; j < COLS_PER_CYCLE; j++) begin
      work_d[col_lsb(beat_q, j) +: 32] = mix_out[j];
    end
  end

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    aes_mixcol_word u_word (
      .col (mix_in[g]),
      .inv (mode_inv),
      .res (mix_out[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      work_q  <= '0;
`ifdef AES_MIXCOL_INV_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (accept) begin
        work_q <= bus.in_state;
`ifdef AES_MIXCOL_INV_EN
        mode_q <= bus.in_inv;
`endif
      end else if (state_q == BUSY) begin
        work_q <= work_d;
      end
    end
  end

endmodule
